// File: rtl/klp32_mem_pkg.sv
// Shared types and default widths for the klp32 memory-port logic.
package klp32_mem_pkg;

  localparam int KLP32_AW = 32;
  localparam int KLP32_DW = 32;
  localparam logic [3:0] BE_FULL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2
  } arb_state_e;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Winner select with fetch-starvation guard for mem_port_arbiter.
// Built only when ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr
  import klp32_mem_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic decide_i,
  input  logic if_req_i,
  input  logic ls_req_i,
  output logic pick_ls_o
);

  localparam int CW = cnt_width(MAX_STARVE);
  localparam logic [CW-1:0] CREDIT_FULL = CW'(MAX_STARVE);

  // Down-counter of ls grants still allowed while fetch waits; zero is terminal.
  logic [CW-1:0] credit_q, credit_d;
  logic          starved;

  assign starved   = (credit_q == '0);
  assign pick_ls_o = ls_req_i && !(if_req_i && starved);

  always_comb begin
    credit_d = credit_q;
    if (decide_i) begin
      if (pick_ls_o && if_req_i) begin
        credit_d = credit_q - CW'(1);
      end else begin
        credit_d = CREDIT_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CREDIT_FULL;
    end else begin
      credit_q <= credit_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master (fetch, load/store) arbiter onto a single-outstanding memory port.
// Define ARB_STARVE_GUARD_EN to bound how long fetch can be starved by ls.
//
// state      | meaning
// ST_IDLE    | no transaction; arbitrate on any req
// ST_BUSY_IF | fetch outstanding, waiting for mem_ack
// ST_BUSY_LS | load/store outstanding, waiting for mem_ack
module mem_port_arbiter
  import klp32_mem_pkg::*;
#(
  parameter int AW         = KLP32_AW,
  parameter int DW         = KLP32_DW,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,

  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [3:0]    ls_be,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,

  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  if (MAX_STARVE < 0) begin : g_param_chk
    $error("mem_port_arbiter: MAX_STARVE must be non-negative");
  end

  arb_state_e    state_q, state_d;
  logic          drop_q, drop_d;
  logic          if_gnt_q, if_gnt_d;
  logic          ls_gnt_q, ls_gnt_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ls_rdata_q, ls_rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;

  logic any_req;
  logic pick_ls;

  assign any_req = if_req | ls_req;

`ifdef ARB_STARVE_GUARD_EN
  logic decide;
  assign decide = (state_q == ST_IDLE) && any_req;

  arb_starve_ctr #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .decide_i  (decide),
    .if_req_i  (if_req),
    .ls_req_i  (ls_req),
    .pick_ls_o (pick_ls)
  );
`else
  assign pick_ls = ls_req;
`endif

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          mem_req_d = 1'b1;
          drop_d    = 1'b0;
          if (pick_ls) begin
            ls_gnt_d    = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            mem_be_d    = ls_be;
            state_d     = ST_BUSY_LS;
          end else begin
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = BE_FULL;
            state_d     = ST_BUSY_IF;
          end
        end
      end

      ST_BUSY_IF: begin
        if (if_flush) begin
          drop_d = 1'b1;
        end
        // A flush coinciding with the ack still discards the fetched word.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          state_d   = ST_IDLE;
          if (!(drop_q || if_flush)) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end

      ST_BUSY_LS: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = mem_rdata;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drop_q      <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, memory address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MAX_STARVE, default 4, consecutive data grants allowed while fetch waits.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have fetch ports if_req in 1, if_addr in AW, if_flush in 1 (taken branch/jump), if_gnt out 1, if_rvalid out 1, if_rdata out DW.
REQ-007 SHALL have load/store ports ls_req in 1, ls_we in 1, ls_addr in AW, ls_wdata in DW, ls_be in 4, ls_gnt out 1, ls_rvalid out 1, ls_rdata out DW.
REQ-008 SHALL have memory ports mem_req out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_be out 4, mem_ack in 1, mem_rdata in DW.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_IF, BUSY_LS; exactly one memory transaction outstanding.
REQ-010 SHALL, in IDLE at a rising edge with any req high, select a winner, register its address/we/wdata/be onto mem_*, and enter BUSY_IF or BUSY_LS.
REQ-011 SHALL pulse the winner's gnt high for exactly the one cycle after the decision edge; requesters hold req and payload stable until gnt.
REQ-012 SHALL hold mem_req high from the cycle after the decision edge until the edge at which mem_ack is sampled high; mem_* payload stable throughout.
REQ-013 SHALL, at the mem_ack edge, register mem_rdata into the owner's rdata, pulse owner's rvalid for one cycle (writes included, as completion), and return to IDLE.
REQ-014 SHALL give minimum latency: req at cycle 0, gnt and mem_req at cycle 1, mem_ack at cycle 1, rvalid at cycle 2, next decision at the cycle-2 edge.
REQ-015 SHALL prioritise ls over if when both requests are high at a decision edge.
REQ-016 SHALL ignore all req inputs while in BUSY_IF or BUSY_LS.
REQ-017 SHALL, if if_flush is high at any edge in BUSY_IF, set a drop flag; the transaction completes on the memory side but if_rvalid is suppressed.
REQ-018 SHALL suppress if_rvalid when if_flush and mem_ack coincide; if_flush in IDLE or BUSY_LS has no effect.
REQ-019 SHALL keep if_rdata/ls_rdata holding their last value when not updated; mem_we is 0 for fetches, mem_be is 4'b1111 for fetches.

Reset
REQ-020 SHALL, with rst high at an edge, enter IDLE, clear drop flag and starve counter, and drive gnt, rvalid, mem_req, mem_we low and all data/address outputs zero on the next cycle.
REQ-021 SHALL abandon an in-flight transaction on reset mid-operation; a later mem_ack in IDLE is ignored and produces no rvalid.

Configuration
REQ-022 SHALL, with ARB_STARVE_GUARD_EN defined, count consecutive ls grants made while if_req was high; when the count equals MAX_STARVE, the next decision with if_req high grants fetch; the count clears on any fetch grant or any decision with if_req low.
REQ-023 SHALL, without ARB_STARVE_GUARD_EN, use strict ls priority with no counter logic.

Structure
REQ-024 SHALL place the FSM state enum and the default AW/DW constants in shared package klp32_mem_pkg.
REQ-025 SHALL isolate the starvation counter and the winner-select logic in sub-module arb_starve_ctr, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-026 SHALL test: if_req, if_addr=0x100, mem_ack on cycle 1, mem_rdata=0xDEADBEEF -> if_gnt at cycle 1, if_rvalid with if_rdata=0xDEADBEEF at cycle 2.
REQ-027 SHALL test: if_req and ls_req (ls_we=1, ls_addr=0x2000, ls_wdata=0x55) together -> ls served first with mem_we=1 and mem_addr=0x2000, fetch granted at the following decision.
REQ-028 SHALL test: mem_ack delayed 5 cycles -> mem_req high and payload stable for all 5 cycles, one rvalid pulse.
REQ-029 SHALL test: if_flush in cycle 2 of a 4-cycle fetch, and separately coincident with mem_ack -> no if_rvalid in either case, FSM back in IDLE.
REQ-030 SHALL test (ARB_STARVE_GUARD_EN, MAX_STARVE=4): if_req and ls_req held continuously -> grant order ls,ls,ls,ls,if,ls...; without the macro -> ls only.
REQ-031 SHALL test: rst asserted while in BUSY_LS, then mem_ack -> all outputs zero after reset, no ls_rvalid.
